// File: rtl/menu_ctrl.sv
// menu_ctrl: debounced up/down/select buttons driving a browse/edit/commit menu and its 8-char line word.
// Optional: define MENU_AUTOREPEAT_EN for hold-to-repeat of up/down while editing.
module menu_ctrl #(
  parameter int N_ITEMS    = 4,
  parameter int VAL_MAX    = 63,
  parameter int DEBOUNCE   = 50000,
  parameter int REPEAT_DLY = 250000,
  parameter int REPEAT_PER = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic        newframe,
  output logic [31:0] line,
  output logic [3:0]  item_idx,
  output logic [5:0]  item_value,
  output logic        editing,
  output logic        commit,
  output logic [3:0]  commit_idx
);
  localparam int              IW       = $clog2(N_ITEMS);
  localparam int              DB_W     = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [3:0]      IDX_LAST = 4'(N_ITEMS - 1);
  localparam logic [5:0]      VMAX     = 6'(VAL_MAX);

  if (N_ITEMS < 2 || N_ITEMS > 10 || VAL_MAX > 63 || REPEAT_PER < 1 || REPEAT_DLY < REPEAT_PER) begin : g_param_err
    $error("menu_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {BROWSE = 2'd0, EDIT = 2'd1, COMMIT = 2'd2} state_t;
  state_t state, state_nx;

  logic [2:0]      raw, sync1, sync2, level, press;
  logic [DB_W-1:0] db_cnt [3];
  logic [3:0]      idx_nx;
  logic [5:0]      edit_val, edit_val_nx;
  logic [5:0]      stored [N_ITEMS];
  logic [5:0]      shown;
  logic [3:0]      mode_char;
  logic            ev_up, ev_down, ev_sel;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  assign raw = {btn_sel, btn_down, btn_up};

  // Synchronise each button, accept a level change after DEBOUNCE stable cycles, pulse on accepted rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      level <= 3'b000;
      press <= 3'b000;
      for (int b = 0; b < 3; b++) db_cnt[b] <= {DB_W{1'b0}};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int b = 0; b < 3; b++) begin
        press[b] <= 1'b0;
        if (sync2[b] != level[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            level[b]  <= ~level[b];
            press[b]  <= ~level[b];
            db_cnt[b] <= {DB_W{1'b0}};
          end else begin
            db_cnt[b] <= db_cnt[b] + DB_ONE;
          end
        end else begin
          db_cnt[b] <= {DB_W{1'b0}};
        end
      end
    end
  end

`ifdef MENU_AUTOREPEAT_EN
  localparam int              RP_W      = $clog2(REPEAT_DLY + 1);
  localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DLY - 1);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DLY - REPEAT_PER);
  localparam logic [RP_W-1:0] RP_ONE    = RP_W'(1);
  logic [RP_W-1:0] rep_cnt [2];
  logic [1:0]      rep;

  // Hold timers for up/down while editing: first repeat REPEAT_DLY after the press, then every REPEAT_PER.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep <= 2'b00;
      for (int b = 0; b < 2; b++) rep_cnt[b] <= {RP_W{1'b0}};
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (state == EDIT && level[b]) begin
          if (rep_cnt[b] == RP_LAST) begin
            rep[b]     <= 1'b1;
            rep_cnt[b] <= RP_RELOAD;
          end else begin
            rep[b]     <= 1'b0;
            rep_cnt[b] <= rep_cnt[b] + RP_ONE;
          end
        end else begin
          rep[b]     <= 1'b0;
          rep_cnt[b] <= {RP_W{1'b0}};
        end
      end
    end
  end

  assign ev_up   = press[0] | rep[0];
  assign ev_down = press[1] | rep[1];
`else
  assign ev_up   = press[0];
  assign ev_down = press[1];
`endif
  assign ev_sel = press[2];

  // State, item index, edit value, stored values and the frame-synchronous line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BROWSE;
      item_idx <= 4'd0;
      edit_val <= 6'd0;
      line     <= 32'hEECB00F0;
      for (int i = 0; i < N_ITEMS; i++) stored[i] <= 6'd0;
    end else begin
      state    <= state_nx;
      item_idx <= idx_nx;
      edit_val <= edit_val_nx;
      if (state == COMMIT) stored[item_idx[IW-1:0]] <= edit_val;
      if (newframe) line <= {16'hEECB, bcd_ones(shown), bcd_tens(shown), mode_char, item_idx};
    end
  end

  // Next-state: sel has priority; up and down together cancel; COMMIT ignores all pulses.
  always_comb begin
    state_nx    = state;
    idx_nx      = item_idx;
    edit_val_nx = edit_val;
    case (state)
      BROWSE: begin
        if (ev_sel) begin
          state_nx    = EDIT;
          edit_val_nx = item_value;
        end else if (ev_up && !ev_down) begin
          idx_nx = (item_idx == 4'd0) ? IDX_LAST : item_idx - 4'd1;
        end else if (ev_down && !ev_up) begin
          idx_nx = (item_idx == IDX_LAST) ? 4'd0 : item_idx + 4'd1;
        end else begin
          state_nx = BROWSE;
        end
      end
      EDIT: begin
        if (ev_sel) begin
          state_nx = COMMIT;
        end else if (ev_up && !ev_down) begin
          edit_val_nx = (edit_val >= VMAX) ? VMAX : edit_val + 6'd1;
        end else if (ev_down && !ev_up) begin
          edit_val_nx = (edit_val == 6'd0) ? 6'd0 : edit_val - 6'd1;
        end else begin
          state_nx = EDIT;
        end
      end
      COMMIT:  state_nx = BROWSE;
      default: state_nx = BROWSE;
    endcase
  end

  // Output decode and the value/marker shown on the line.
  always_comb begin
    editing    = (state == EDIT);
    commit     = (state == COMMIT);
    commit_idx = item_idx;
    item_value = stored[item_idx[IW-1:0]];
    shown      = (state == EDIT) ? edit_val : item_value;
    mode_char  = (state == EDIT) ? 4'd12 : 4'd15;
  end
endmodule

// File: tb/tb_menu_ctrl.sv
// Scoreboard bench for menu_ctrl: a behavioural menu model predicts every cycle's outputs into a queue,
// a negedge monitor pops and compares. Directed menu walks followed by randomized button activity.
module tb_menu_ctrl;
  localparam int N    = 4;
  localparam int VMAX = 63;
  localparam int DB   = 4;
  localparam int RDLY = 20;
  localparam int RPER = 5;
`ifdef MENU_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, newframe = 1'b0;
  logic [31:0] line;
  logic [3:0]  item_idx, commit_idx;
  logic [5:0]  item_value;
  logic        editing, commit;

  menu_ctrl #(.N_ITEMS(N), .VAL_MAX(VMAX), .DEBOUNCE(DB), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .newframe(newframe), .line(line), .item_idx(item_idx), .item_value(item_value),
    .editing(editing), .commit(commit), .commit_idx(commit_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] line;
    logic [3:0]  idx;
    logic [5:0]  val;
    logic        editing;
    logic        commit;
    logic [3:0]  cidx;
  } snap_t;

  snap_t expq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    nf_cnt = 0;

  // Behavioural model: mode 0 = browsing, 1 = editing, 2 = committing
  int          m_mode, m_idx, m_val;
  int          m_store [N];
  logic [31:0] m_line;
  int          m_s1 [3], m_s2 [3], m_lvl [3], m_run [3], m_press [3];
  int          m_hold [2], m_rep [2];

  task automatic model_step(input logic [2:0] raw, input logic nf, input logic r);
    int eu, ed, es, shown, old_mode;
    if (r) begin
      m_mode = 0; m_idx = 0; m_val = 0; m_line = 32'hEECB00F0;
      for (int i = 0; i < N; i++) m_store[i] = 0;
      for (int b = 0; b < 3; b++) begin m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_press[b] = 0; end
      for (int b = 0; b < 2; b++) begin m_hold[b] = 0; m_rep[b] = 0; end
    end else begin
      old_mode = m_mode;
      if (nf) begin
        shown  = (m_mode == 1) ? m_val : m_store[m_idx];
        m_line = {16'hEECB, 4'(shown % 10), 4'(shown / 10), (m_mode == 1) ? 4'd12 : 4'd15, 4'(m_idx)};
      end
      eu = m_press[0] | m_rep[0];
      ed = m_press[1] | m_rep[1];
      es = m_press[2];
      if (m_mode == 0) begin
        if (es != 0) begin m_mode = 1; m_val = m_store[m_idx]; end
        else if (eu != 0 && ed == 0) m_idx = (m_idx + N - 1) % N;
        else if (ed != 0 && eu == 0) m_idx = (m_idx + 1) % N;
      end else if (m_mode == 1) begin
        if (es != 0) m_mode = 2;
        else if (eu != 0 && ed == 0) m_val = (m_val < VMAX) ? m_val + 1 : VMAX;
        else if (ed != 0 && eu == 0) m_val = (m_val > 0) ? m_val - 1 : 0;
      end else begin
        m_store[m_idx] = m_val;
        m_mode = 0;
      end
      for (int b = 0; b < 2; b++) begin
        m_rep[b] = 0;
        if (AUTO && old_mode == 1 && m_lvl[b] != 0) begin
          m_hold[b]++;
          if (m_hold[b] >= RDLY && (m_hold[b] - RDLY) % RPER == 0) m_rep[b] = 1;
        end else m_hold[b] = 0;
      end
      for (int b = 0; b < 3; b++) begin
        m_press[b] = 0;
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin m_lvl[b] = 1 - m_lvl[b]; m_run[b] = 0; m_press[b] = m_lvl[b]; end
        end else m_run[b] = 0;
        m_s2[b] = m_s1[b];
        m_s1[b] = int'(raw[b]);
      end
    end
  endtask

  function automatic snap_t make_snap();
    snap_t s;
    s.line    = m_line;
    s.idx     = 4'(m_idx);
    s.val     = 6'(m_store[m_idx]);
    s.editing = (m_mode == 1);
    s.commit  = (m_mode == 2);
    s.cidx    = 4'(m_idx);
    return s;
  endfunction

  function automatic logic nf_tick();
    nf_cnt++;
    return (nf_cnt % 5 == 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive on negedge, let the model see the same inputs on the posedge, queue the prediction.
  task automatic step(input logic u, input logic d, input logic s, input logic nf, input logic r);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_sel = s; newframe = nf; rst = r;
    @(posedge clk);
    model_step({s, d, u}, nf, r);
    expq.push_back(make_snap());
  endtask

  task automatic press(input logic u, input logic d, input logic s, input int hold);
    for (int i = 0; i < hold; i++) step(u, d, s, nf_tick(), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, nf_tick(), 1'b0);
  endtask

  always @(negedge clk) begin
    snap_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("line", line, e.line);
      check("item_idx", 32'(item_idx), 32'(e.idx));
      check("item_value", 32'(item_value), 32'(e.val));
      check("editing", 32'(editing), 32'(e.editing));
      check("commit", 32'(commit), 32'(e.commit));
      if (e.commit) check("commit_idx", 32'(commit_idx), 32'(e.cidx));
    end
  end

  initial begin
    logic [2:0] rb;
    model_step(3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, (i % 2 == 0), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // short glitch and bounces on down must not register
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b0, 1'b1, 1'b0, 8);
    press(1'b0, 0, 1'b1, 8);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0, 8);
    press(1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, nf_tick(), 1'b0);
    // saturation at both ends, cancelling up+down, sel beating up
    press(1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 62; i++) press(1'b1, 1'b0, 1'b0, 6);
    for (int i = 0; i < 66; i++) press(1'b0, 1'b1, 1'b0, 6);
    press(1'b1, 1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 1'b1, 8);
    // abandon an edit with reset
    press(1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0, 6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, nf_tick(), 1'b0);
    if (AUTO) begin
      press(1'b0, 1'b0, 1'b1, 8);
      press(1'b1, 1'b0, 1'b0, 46);
      press(1'b0, 1'b0, 1'b1, 8);
    end
    rb = 3'b000;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(7) == 0) rb[0] = ~rb[0];
      if ($urandom_range(7) == 0) rb[1] = ~rb[1];
      if ($urandom_range(19) == 0) rb[2] = ~rb[2];
      step(rb[0], rb[1], rb[2], ($urandom_range(3) == 0), ($urandom_range(1499) == 0));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
